ikaopll_lfo_gen: RTL and testbench

Parametrised next-generation LFO for the IKAOPLL operator pipeline. It produces the per-frame vibrato (PM) index and tremolo (AM) attenuation consumed by the phase generator and envelope/attenuation stage. Depth and rate are generalised through parameters, and the AM path uses a parallel up/down triangle counter. It adds a runtime AM depth select and a configurable PM divider.

---
 rtl/ikaopll_lfo_pkg.sv | 21 ++
 rtl/ikaopll_lfo_tri.sv | 59 +++++
 rtl/ikaopll_lfo_gen.sv | 114 +++++++++++
 tb/tb_ikaopll_lfo_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ikaopll_lfo_pkg.sv
// rtl/ikaopll_lfo_pkg.sv - shared constants and encodings for the IKAOPLL LFO
package ikaopll_lfo_pkg;

  localparam int PRESC_W_DEF       = 6;
  localparam int PM_DIV_W_DEF      = 4;
  localparam int PM_W_DEF          = 3;
  localparam int AM_W_DEF          = 8;
  localparam int AM_TOP_OPLL       = 105;
  localparam int AM_OUTW_DEF       = 4;
  localparam int AM_SH_DEEP_DEF    = 3;
  localparam int AM_SH_SHALLOW_DEF = 5;

  localparam int TEST_CLR  = 1;
  localparam int TEST_FAST = 3;

  typedef enum logic {
    AM_DIR_UP   = 1'b0,
    AM_DIR_DOWN = 1'b1
  } am_dir_e;

endpackage

// File: rtl/ikaopll_lfo_tri.sv
// rtl/ikaopll_lfo_tri.sv - up/down triangle counter driving the tremolo depth
module ikaopll_lfo_tri
  import ikaopll_lfo_pkg::*;
#(
  parameter int AM_W   = AM_W_DEF,
  parameter int AM_TOP = AM_TOP_OPLL
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            step_i,
  output logic [AM_W-1:0] cnt_o
);

  localparam logic [AM_W-1:0] TOP_V = AM_W'(AM_TOP);

  logic [AM_W-1:0] cnt_q, cnt_d;
  am_dir_e         dir_q, dir_d;

  // The turn-around steps jump straight to the neighbour so each peak is held one step only.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (clr_i) begin
      cnt_d = '0;
      dir_d = AM_DIR_UP;
    end else if (step_i) begin
      if (dir_q == AM_DIR_UP) begin
        if (cnt_q == TOP_V) begin
          dir_d = AM_DIR_DOWN;
          cnt_d = TOP_V - AM_W'(1);
        end else begin
          cnt_d = cnt_q + AM_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          dir_d = AM_DIR_UP;
          cnt_d = AM_W'(1);
        end else begin
          cnt_d = cnt_q - AM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      dir_q <= AM_DIR_UP;
    end else if (en_i) begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ikaopll_lfo_gen.sv
// rtl/ikaopll_lfo_gen.sv - LFO producing latched vibrato index and tremolo attenuation
module ikaopll_lfo_gen
  import ikaopll_lfo_pkg::*;
#(
  parameter int PRESC_W       = PRESC_W_DEF,
  parameter int PM_DIV_W      = PM_DIV_W_DEF,
  parameter int PM_W          = PM_W_DEF,
  parameter int AM_W          = AM_W_DEF,
  parameter int AM_TOP        = AM_TOP_OPLL,
  parameter int AM_OUTW       = AM_OUTW_DEF,
  parameter int AM_SH_DEEP    = AM_SH_DEEP_DEF,
  parameter int AM_SH_SHALLOW = AM_SH_SHALLOW_DEF
) (
  input  logic               i_EMUCLK,
  input  logic               i_IC_n,
  input  logic               i_phi1_PCEN_n,
  input  logic               i_phi1_NCEN_n,
  input  logic               i_CYCLE_00,
  input  logic               i_CYCLE_21,
  input  logic [3:0]         i_TEST,
  input  logic               i_AM_DEEP,
  output logic [PM_W-1:0]    o_PMVAL,
  output logic [AM_OUTW-1:0] o_AMVAL
);

  if ((AM_TOP >> AM_SH_DEEP) >= (1 << AM_OUTW)) begin : g_bad_depth
    $error("ikaopll_lfo_gen: AM_TOP >> AM_SH_DEEP does not fit in AM_OUTW bits");
  end
  if (AM_TOP >= (1 << AM_W)) begin : g_bad_top
    $error("ikaopll_lfo_gen: AM_TOP does not fit in AM_W bits");
  end

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PM_DIV_W-1:0] pm_div_q, pm_div_d;
  logic [PM_W-1:0]     pm_cnt_q, pm_cnt_d;
  logic [PM_W-1:0]     pmval_q, pmval_d;
  logic [AM_OUTW-1:0]  amval_q, amval_d;
  logic [AM_W-1:0]     am_cnt;
  logic [AM_W-1:0]     am_shifted;

  logic upd_en, latch_en, clr, fast, presc_co, pm_co, pm_step, am_step;
  logic unused_test;

  assign upd_en      = ~i_phi1_NCEN_n;
  assign latch_en    = ~i_phi1_PCEN_n & i_CYCLE_00;
  assign clr         = i_TEST[TEST_CLR];
  assign fast        = i_CYCLE_21 & i_TEST[TEST_FAST];
  assign presc_co    = (&presc_q) & i_CYCLE_21;
  assign pm_co       = (&pm_div_q) & presc_co;
  assign pm_step     = pm_co | fast;
  assign am_step     = presc_co | fast;
  assign unused_test = ^{i_TEST[0], i_TEST[2]};

  always_comb begin
    presc_d  = presc_q;
    pm_div_d = pm_div_q;
    pm_cnt_d = pm_cnt_q;
    if (clr) begin
      presc_d  = '0;
      pm_div_d = '0;
      pm_cnt_d = '0;
    end else begin
      if (i_CYCLE_21) presc_d  = presc_q + PRESC_W'(1);
      if (presc_co)   pm_div_d = pm_div_q + PM_DIV_W'(1);
      if (pm_step)    pm_cnt_d = pm_cnt_q + PM_W'(1);
    end
  end

  ikaopll_lfo_tri #(
    .AM_W   (AM_W),
    .AM_TOP (AM_TOP)
  ) u_tri (
    .clk_i   (i_EMUCLK),
    .rst_n_i (i_IC_n),
    .en_i    (upd_en),
    .clr_i   (clr),
    .step_i  (am_step),
    .cnt_o   (am_cnt)
  );

  // Depth is chosen at latch time only, so i_AM_DEEP may toggle freely mid-frame.
  assign am_shifted = i_AM_DEEP ? (am_cnt >> AM_SH_DEEP) : (am_cnt >> AM_SH_SHALLOW);

  always_comb begin
    pmval_d = pmval_q;
    amval_d = amval_q;
    if (latch_en) begin
      pmval_d = pm_cnt_q;
      amval_d = am_shifted[AM_OUTW-1:0];
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      presc_q  <= '0;
      pm_div_q <= '0;
      pm_cnt_q <= '0;
      pmval_q  <= '0;
      amval_q  <= '0;
    end else begin
      if (upd_en) begin
        presc_q  <= presc_d;
        pm_div_q <= pm_div_d;
        pm_cnt_q <= pm_cnt_d;
      end
      pmval_q <= pmval_d;
      amval_q <= amval_d;
    end
  end

  assign o_PMVAL = pmval_q;
  assign o_AMVAL = amval_q;

endmodule

// File: tb/tb_ikaopll_lfo_gen.sv
// tb/tb_ikaopll_lfo_gen.sv - randomized self-checking bench for ikaopll_lfo_gen
module tb_ikaopll_lfo_gen;

  localparam int PRESC_N = 64;
  localparam int PM_N    = 16;
  localparam int PM_MOD  = 8;
  localparam int TOP     = 105;

  logic       clk = 1'b0;
  logic       ic_n = 1'b0;
  logic       pcen_n = 1'b1;
  logic       ncen_n = 1'b1;
  logic       c00 = 1'b0;
  logic       c21 = 1'b0;
  logic [3:0] test = 4'd0;
  logic       deep = 1'b0;
  logic [2:0] pmval;
  logic [3:0] amval;

  int checks = 0;
  int errors = 0;

  int n21;
  int pm_steps;
  int am_steps;
  int exp_pm;
  int exp_am;

  ikaopll_lfo_gen dut (
    .i_EMUCLK      (clk),
    .i_IC_n        (ic_n),
    .i_phi1_PCEN_n (pcen_n),
    .i_phi1_NCEN_n (ncen_n),
    .i_CYCLE_00    (c00),
    .i_CYCLE_21    (c21),
    .i_TEST        (test),
    .i_AM_DEEP     (deep),
    .o_PMVAL       (pmval),
    .o_AMVAL       (amval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int am_value();
    int p = am_steps % (2 * TOP);
    return (p <= TOP) ? p : (2 * TOP - p);
  endfunction

  function automatic int am_down();
    int p = am_steps % (2 * TOP);
    return (p > TOP || (p == 0 && am_steps > 0)) ? 1 : 0;
  endfunction

  task automatic model_clear();
    n21 = 0;
    pm_steps = 0;
    am_steps = 0;
  endtask

  task automatic model_frame_step(input bit fast, input bit clr);
    if (clr) begin
      model_clear();
    end else begin
      n21++;
      if ((n21 % (PRESC_N * PM_N)) == 0 || fast) pm_steps++;
      if ((n21 % PRESC_N) == 0 || fast) am_steps++;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pmval"}, int'(pmval), exp_pm);
    chk({ctx, ".amval"}, int'(amval), exp_am);
    chk({ctx, ".amcnt"}, int'(dut.am_cnt), am_value());
    chk({ctx, ".amdir"}, int'(dut.u_tri.dir_q), am_down());
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ic_n   = 1'b0;
      pcen_n = 1'($urandom_range(0, 1));
      ncen_n = 1'($urandom_range(0, 1));
      c00    = 1'($urandom_range(0, 1));
      c21    = 1'($urandom_range(0, 1));
      test   = 4'($urandom_range(0, 15));
      deep   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ic_n = 1'b1; pcen_n = 1'b1; ncen_n = 1'b1; c00 = 1'b0; c21 = 1'b0; test = 4'd0;
    model_clear();
    exp_pm = 0;
    exp_am = 0;
    @(posedge clk);
    #1;
    check_all("reset");
  endtask

  task automatic frame(input bit fast, input bit clr, input bit dp);
    if ($urandom_range(0, 3) == 0) begin
      // strobes with both enables off must not disturb anything
      @(negedge clk);
      ncen_n = 1'b1; pcen_n = 1'b1; c21 = 1'b1; c00 = 1'b1;
      test = 4'($urandom_range(0, 15));
      deep = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ncen_n = 1'b0; pcen_n = 1'($urandom_range(0, 1)); c21 = 1'b1; c00 = 1'b0;
    test = {fast, 1'($urandom_range(0, 1)), clr, 1'($urandom_range(0, 1))};
    deep = 1'($urandom_range(0, 1));
    model_frame_step(fast, clr);
    @(negedge clk);
    ncen_n = 1'($urandom_range(0, 1)); pcen_n = 1'b0; c21 = 1'b0; c00 = 1'b1;
    test = {1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1))};
    deep = dp;
    exp_pm = pm_steps % PM_MOD;
    exp_am = (am_value() >> (dp ? 3 : 5)) & 15;
    @(posedge clk);
    #1;
    check_all("frame");
  endtask

  initial begin
    model_clear();
    exp_pm = 0;
    exp_am = 0;

    do_reset();

    // normal rate: one AM step per 64 frames, one PM step per 1024
    for (int i = 1; i <= PRESC_N * PM_N; i++) begin
      frame(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (i == 64)   chk("norm.am64", int'(dut.am_cnt), 1);
      if (i == 1023) chk("norm.pm1023", int'(pmval), 0);
      if (i == 1024) chk("norm.pm1024", int'(pmval), 1);
    end

    for (int i = 0; i < 20; i++) frame(1'b1, 1'b0, 1'b1);
    do_reset();
    chk("reset.amcnt0", int'(dut.am_cnt), 0);

    // fast mode deep
    for (int i = 1; i <= 211; i++) begin
      frame(1'b1, 1'b0, 1'b1);
      if (i == 105) begin
        chk("fast.peak", int'(dut.am_cnt), 105);
        chk("fast.peakam", int'(amval), 13);
      end
      if (i == 106) chk("fast.106", int'(dut.am_cnt), 104);
      if (i == 210) chk("fast.210", int'(dut.am_cnt), 0);
      if (i == 211) begin
        chk("fast.211", int'(dut.am_cnt), 1);
        chk("fast.211dir", int'(dut.u_tri.dir_q), 0);
      end
    end

    // depth select at the peak
    do_reset();
    for (int i = 0; i < 105; i++) frame(1'b1, 1'b0, 1'b1);
    chk("depth.deep", int'(amval), 13);
    frame(1'b0, 1'b0, 1'b0);
    chk("depth.shallow", int'(amval), 3);

    // clear colliding with a prescaler carry
    do_reset();
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 58; i++) frame(1'b0, 1'b0, 1'b1);
    chk("clr.presc63", int'(dut.presc_q), 63);
    frame(1'b0, 1'b1, 1'b1);
    chk("clr.presc", int'(dut.presc_q), 0);
    chk("clr.pmcnt", int'(dut.pm_cnt_q), 0);
    chk("clr.amcnt", int'(dut.am_cnt), 0);
    chk("clr.pmval", int'(pmval), 0);
    chk("clr.amval", int'(amval), 0);

    // PM wrap in fast mode
    do_reset();
    for (int i = 0; i < 7; i++) frame(1'b1, 1'b0, 1'b0);
    chk("wrap.start", int'(pmval), 7);
    for (int j = 1; j <= 8; j++) begin
      frame(1'b1, 1'b0, 1'b0);
      chk("wrap.seq", int'(pmval), j - 1);
    end

    // random mix
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      frame(1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
